// File: rtl/vga_pixel_scanner.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_scanner
// Brief    : VGA raster timing with one frame-buffer color fetch per active pixel
// Revision : 1.0
// ============================================================================
module vga_pixel_scanner #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_en,
  output logic              fb_rd,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [2:0]        fb_data,
  output logic [2:0]        color,
  output logic              hsync_n,
  output logic              vsync_n,
  output logic              blank_n,
  output logic              frame_start
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int c_hw      = $clog2(c_h_total);
  localparam int c_vw      = $clog2(c_v_total);

  localparam logic [c_hw-1:0] c_h_last     = c_hw'(c_h_total - 1);
  localparam logic [c_hw-1:0] c_h_act      = c_hw'(H_ACTIVE);
  localparam logic [c_hw-1:0] c_hs_start   = c_hw'(H_ACTIVE + H_FP);
  localparam logic [c_hw-1:0] c_hs_end     = c_hw'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [c_vw-1:0] c_v_last     = c_vw'(c_v_total - 1);
  localparam logic [c_vw-1:0] c_v_act      = c_vw'(V_ACTIVE);
  localparam logic [c_vw-1:0] c_vs_start   = c_vw'(V_ACTIVE + V_FP);
  localparam logic [c_vw-1:0] c_vs_end     = c_vw'(V_ACTIVE + V_FP + V_SYNC);

  logic [c_hw-1:0]   r_h_cnt;
  logic [c_vw-1:0]   r_v_cnt;
  logic [ADDR_W-1:0] r_addr;

  // One-tick delay of the raster decode, lining it up with the RAM read latency
  logic r_p_active;
  logic r_p_hsync;
  logic r_p_vsync;
  logic r_p_first;

  logic w_h_last;
  logic w_v_last;
  logic w_active;
  logic w_hs_zone;
  logic w_vs_zone;
  logic w_first;

  assign w_h_last  = (r_h_cnt == c_h_last);
  assign w_v_last  = (r_v_cnt == c_v_last);
  assign w_active  = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
  assign w_hs_zone = (r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end);
  assign w_vs_zone = (r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end);
  assign w_first   = (r_h_cnt == '0) && (r_v_cnt == '0);

  // Gated by reset so no read is issued while the raster is held
  assign fb_rd   = reset_n & pix_en & w_active;
  assign fb_addr = r_addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_cnt    <= '0;
      r_v_cnt    <= '0;
      r_addr     <= '0;
      r_p_active <= 1'b0;
      r_p_hsync  <= 1'b0;
      r_p_vsync  <= 1'b0;
      r_p_first  <= 1'b0;
      color      <= 3'd0;
      blank_n    <= 1'b0;
      hsync_n    <= 1'b1;
      vsync_n    <= 1'b1;
    end else if (pix_en) begin
      r_h_cnt <= w_h_last ? '0 : r_h_cnt + c_hw'(1);
      if (w_h_last) begin
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + c_vw'(1);
      end
      if (w_h_last && w_v_last) begin
        r_addr <= '0;
      end else if (w_active) begin
        r_addr <= r_addr + ADDR_W'(1);
      end

      r_p_active <= w_active;
      r_p_hsync  <= w_hs_zone;
      r_p_vsync  <= w_vs_zone;
      r_p_first  <= w_first;

      color   <= r_p_active ? fb_data : 3'd0;
      blank_n <= r_p_active;
      hsync_n <= ~r_p_hsync;
      vsync_n <= ~r_p_vsync;
    end
  end

  // Cleared on every non-tick clk so the pulse stays one clk wide
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en & r_p_first;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_scanner.sv
`default_nettype none
// Scoreboard bench for vga_pixel_scanner on a shrunken raster (15x8 ticks per frame,
// 8x4 visible); expectations come from a closed-form model of the tick index.
module tb_vga_pixel_scanner;

  localparam int HT = 15;
  localparam int VT = 8;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pix_en;
  logic       fb_rd;
  logic [5:0] fb_addr;
  logic [2:0] fb_data = 3'd0;
  logic [2:0] color;
  logic       hsync_n;
  logic       vsync_n;
  logic       blank_n;
  logic       frame_start;

  vga_pixel_scanner #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .ADDR_W(6)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_data(fb_data),
    .color(color), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .blank_n(blank_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int color;
    int blank_n;
    int hsync_n;
    int vsync_n;
    int frame_start;
    int fb_rd;
    int fb_addr;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   t        = 0;

  function automatic int memf(input int a);
    return (a ^ (a >> 3)) & 7;
  endfunction

  function automatic int f_h(input int s);
    return s % HT;
  endfunction

  function automatic int f_v(input int s);
    return (s / HT) % VT;
  endfunction

  function automatic int f_act(input int s);
    return (f_h(s) < 8 && f_v(s) < 4) ? 1 : 0;
  endfunction

  // Number of visible pixels already fetched in the current frame
  function automatic int f_addr(input int s);
    int h, v;
    h = f_h(s);
    v = f_v(s);
    if (v < 4) return v * 8 + ((h < 8) ? h : 8);
    return 32;
  endfunction

  always @(posedge clk) begin
    if (fb_rd) fb_data <= 3'(memf(int'(fb_addr)));
  end

  function automatic void chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endfunction

  task automatic step(input logic en, input logic rst);
    exp_t e;
    int   s;
    logic last_tick;
    @(posedge clk);
    #1;
    last_tick = pix_en & reset_n;
    reset_n   = rst;
    pix_en    = en;
    if (!rst) t = 0;
    if (t >= 2) begin
      s             = t - 2;
      e.blank_n     = f_act(s);
      e.color       = f_act(s) ? memf(f_addr(s)) : 0;
      e.hsync_n     = (f_h(s) >= 10 && f_h(s) < 13) ? 0 : 1;
      e.vsync_n     = (f_v(s) >= 5 && f_v(s) < 7) ? 0 : 1;
      e.frame_start = (last_tick && (s % FT) == 0) ? 1 : 0;
    end else begin
      e.blank_n     = 0;
      e.color       = 0;
      e.hsync_n     = 1;
      e.vsync_n     = 1;
      e.frame_start = 0;
    end
    e.fb_rd   = (rst && en && f_act(t) == 1) ? 1 : 0;
    e.fb_addr = f_addr(t);
    q.push_back(e);
    if (rst && en) t++;
  endtask

  initial begin : monitor
    exp_t m;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        m = q.pop_front();
        chk("color",       int'(color),       m.color);
        chk("blank_n",     int'(blank_n),     m.blank_n);
        chk("hsync_n",     int'(hsync_n),     m.hsync_n);
        chk("vsync_n",     int'(vsync_n),     m.vsync_n);
        chk("frame_start", int'(frame_start), m.frame_start);
        chk("fb_rd",       int'(fb_rd),       m.fb_rd);
        chk("fb_addr",     int'(fb_addr),     m.fb_addr);
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    reset_n = 1'b0;
    pix_en  = 1'b0;
    for (int i = 0; i < 6; i++) step(1'(i % 2), 1'b0);
    // Continuous ticks across a full frame and into the next
    for (int i = 0; i < FT + 10; i++) step(1'b1, 1'b1);
    // Every other clk: waveforms stretched, outputs hold between ticks
    for (int i = 0; i < 2 * FT + 20; i++) step(1'(i % 2 == 0), 1'b1);
    for (int i = 0; i < 60; i++) step(1'($urandom_range(0, 1)), 1'b1);
    // Run to line 2 pixel 5, then reset mid-frame with pix_en toggling
    for (int i = 0; i < 2 * FT && (t % FT) != 2 * HT + 5; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'(i % 2), 1'b0);
    for (int i = 0; i < FT + 10; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
